// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 2KiB data memory between the core
// load/store path and the debug loader, with a bounded burst lock.
module dmem_arbiter #(
  parameter logic [31:0] DMEM_TOP = 32'h0000_07FF,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_c_req,
  input  logic        i_c_wren,
  input  logic [2:0]  i_c_funct3,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  output logic        o_c_gnt,
  output logic        o_c_rvalid,
  output logic [31:0] o_c_rdata,
  output logic        o_c_err,
  input  logic        i_d_req,
  input  logic        i_d_wren,
  input  logic [2:0]  i_d_funct3,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic        i_d_lock,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  output logic        o_m_wren,
  output logic [2:0]  o_m_funct3,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  input  logic [31:0] i_m_rdata
);

  localparam logic [1:0] ST_RR    = 2'd0;
  localparam logic [1:0] ST_LOCK  = 2'd1;
  localparam logic [1:0] ST_YIELD = 2'd2;
  localparam logic [7:0] LMAX     = 8'(LOCK_MAX);

  logic [1:0]  state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic [7:0]  cnt_inc;
  logic        gnt_c, gnt_d;

  logic        c_rvalid_q, c_rvalid_d;
  logic        c_err_q, c_err_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        m_wr;
  logic [2:0]  m_f3;
  logic [31:0] m_addr;
  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        f3_ok;
  logic        legal;

  // rr_ptr: 0 prefers the core, 1 prefers debug
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    gnt_c      = 1'b0;
    gnt_d      = 1'b0;
    cnt_inc    = (lock_cnt_q == LMAX) ? LMAX : lock_cnt_q + 8'd1;
    unique case (state_q)
      ST_LOCK: begin
        if (i_d_req && i_d_lock) begin
          gnt_d      = 1'b1;
          lock_cnt_d = cnt_inc;
          if (cnt_inc == LMAX && i_c_req) begin
            state_d = ST_YIELD;
          end
        end else begin
          gnt_c      = i_c_req;
          gnt_d      = i_d_req && !i_c_req;
          lock_cnt_d = '0;
          state_d    = ST_RR;
        end
      end
      ST_YIELD: begin
        gnt_c      = i_c_req;
        lock_cnt_d = '0;
        state_d    = (i_d_req && i_d_lock) ? ST_LOCK : ST_RR;
      end
      default: begin
        state_d = ST_RR;
        if (i_c_req && i_d_req) begin
          gnt_c    = !rr_ptr_q;
          gnt_d    = rr_ptr_q;
          rr_ptr_d = !rr_ptr_q;
        end else begin
          gnt_c = i_c_req;
          gnt_d = i_d_req;
        end
        if (gnt_d && i_d_lock) begin
          lock_cnt_d = 8'd1;
          state_d    = (LMAX == 8'd1 && i_c_req) ? ST_YIELD : ST_LOCK;
        end
      end
    endcase
  end

  assign o_c_gnt = gnt_c && i_rst;
  assign o_d_gnt = gnt_d && i_rst;

  assign m_wr       = o_d_gnt ? i_d_wren   : i_c_wren;
  assign m_f3       = o_d_gnt ? i_d_funct3 : i_c_funct3;
  assign m_addr     = o_d_gnt ? i_d_addr   : i_c_addr;
  assign o_m_wdata  = o_d_gnt ? i_d_wdata  : i_c_wdata;
  assign o_m_funct3 = m_f3;
  assign o_m_addr   = m_addr;

  always_comb begin
    unique case (m_f3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
  end

  // 33-bit end address so accesses near 0xFFFF_FFFF cannot wrap
  assign f3_ok    = (m_f3 == 3'b000) || (m_f3 == 3'b001) ||
                    (m_f3 == 3'b010) ||
                    (!m_wr && (m_f3 == 3'b100 || m_f3 == 3'b101));
  assign end_addr = {1'b0, m_addr} + {30'd0, size} - 33'd1;
  assign legal    = f3_ok && (end_addr <= {1'b0, DMEM_TOP});
  assign o_m_wren = (o_c_gnt || o_d_gnt) && m_wr && legal;

  always_comb begin
    c_rvalid_d = o_c_gnt && (!m_wr || !legal);
    c_err_d    = o_c_gnt && !legal;
    c_rdata_d  = c_rdata_q;
    if (o_c_gnt && !legal) begin
      c_rdata_d = '0;
    end else if (o_c_gnt && !m_wr) begin
      c_rdata_d = i_m_rdata;
    end
    d_rvalid_d = o_d_gnt && (!m_wr || !legal);
    d_err_d    = o_d_gnt && !legal;
    d_rdata_d  = d_rdata_q;
    if (o_d_gnt && !legal) begin
      d_rdata_d = '0;
    end else if (o_d_gnt && !m_wr) begin
      d_rdata_d = i_m_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_RR;
      rr_ptr_q   <= 1'b0;
      lock_cnt_q <= '0;
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      c_rvalid_q <= c_rvalid_d;
      c_err_q    <= c_err_d;
      c_rdata_q  <= c_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign o_c_rvalid = c_rvalid_q;
  assign o_c_err    = c_err_q;
  assign o_c_rdata  = c_rdata_q;
  assign o_d_rvalid = d_rvalid_q;
  assign o_d_err    = d_err_q;
  assign o_d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a
// 2KiB byte memory model behind the arbiter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_wren, d_req, d_wren, d_lock;
  logic [2:0]  c_f3, d_f3;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        m_wren;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic [7:0] mem     [0:2047];
  logic [7:0] ref_mem [0:2047];

  typedef struct {
    int          due;
    logic        rv;
    logic        err;
    logic [31:0] rd;
  } resp_t;

  resp_t       q_c[$];
  resp_t       q_d[$];
  resp_t       mc, md;
  logic [31:0] last_c, last_d;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  dmem_arbiter dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_c_req(c_req), .i_c_wren(c_wren), .i_c_funct3(c_f3),
    .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid),
    .o_c_rdata(c_rdata), .o_c_err(c_err),
    .i_d_req(d_req), .i_d_wren(d_wren), .i_d_funct3(d_f3),
    .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_lock(d_lock),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid),
    .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_m_wren(m_wren), .o_m_funct3(m_f3), .o_m_addr(m_addr),
    .o_m_wdata(m_wdata), .i_m_rdata(m_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    m_rdata = '0;
    for (int k = 0; k < 4; k++)
      m_rdata[8*k +: 8] = mem[11'(m_addr + 32'(k))];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic legal_acc(input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
    logic [32:0] last;
    int          sz;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
          (!wr && (f3 == 3'd4 || f3 == 3'd5))))
      return 1'b0;
    last = {1'b0, a} + 33'(sz) - 33'd1;
    return last <= 33'h7FF;
  endfunction

  task automatic expect_acc(input bit dport, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
    resp_t e;
    int    sz;
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    e.due = cyc + 1;
    e.err = !legal_acc(wr, f3, a);
    e.rd  = '0;
    if (e.err) begin
      e.rv = 1'b1;
    end else if (wr) begin
      e.rv = 1'b0;
      e.rd = dport ? last_d : last_c;
      for (int k = 0; k < sz; k++)
        ref_mem[11'(a + 32'(k))] = wd[8*k +: 8];
    end else begin
      e.rv = 1'b1;
      for (int k = 0; k < 4; k++)
        e.rd[8*k +: 8] = ref_mem[11'(a + 32'(k))];
    end
    if (e.rv) begin
      if (dport) last_d = e.rd;
      else last_c = e.rd;
    end
    if (dport) q_d.push_back(e);
    else q_c.push_back(e);
  endtask

  task automatic set_c(input logic rq, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    c_req = rq; c_wren = wr; c_f3 = f3; c_addr = a; c_wdata = wd;
  endtask

  task automatic set_d(input logic rq, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic lk);
    d_req = rq; d_wren = wr; d_f3 = f3; d_addr = a; d_wdata = wd;
    d_lock = lk;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    set_c(1'b1, 1'b1, 3'd2, 32'h40, 32'h1234_5678);
    set_d(1'b1, 1'b1, 3'd2, 32'h44, 32'h8765_4321, 1'b1);
    @(posedge clk); @(posedge clk); #2;
    n_tests++;
    if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_gnt c=%b d=%b exp 0 0", c_gnt, d_gnt);
    end
    n_tests++;
    if (m_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mwren got %b exp 0", m_wren);
    end
    n_tests++;
    if ({c_rvalid, c_err, c_rdata} !== 34'd0) begin
      n_fail++;
      $display("FAIL rst_c_out rv=%b err=%b rd=%h exp 0", c_rvalid, c_err, c_rdata);
    end
    n_tests++;
    if ({d_rvalid, d_err, d_rdata} !== 34'd0) begin
      n_fail++;
      $display("FAIL rst_d_out rv=%b err=%b rd=%h exp 0", d_rvalid, d_err, d_rdata);
    end
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_core_only();
    @(posedge clk); #1;
    set_c(1'b1, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    #3;
    n_tests++;
    if (c_gnt !== 1'b1 || d_gnt !== 1'b0 || m_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL core_store gnt c=%b d=%b wren=%b exp 1 0 1", c_gnt, d_gnt, m_wren);
    end
    expect_acc(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    set_c(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    #3;
    n_tests++;
    if (c_gnt !== 1'b1 || d_gnt !== 1'b0 || m_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL core_load gnt c=%b d=%b wren=%b exp 1 0 0", c_gnt, d_gnt, m_wren);
    end
    expect_acc(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #3;
    n_tests++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEAD_BEEF || d_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL core_rdata rv=%b rd=%h exp 1 deadbeef", c_rvalid, c_rdata);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_c(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
      set_d(1'b1, 1'b0, 3'd2, 32'h20 + 32'(4*i), 32'h0, 1'b0);
      #3;
      n_tests++;
      if (c_gnt !== (i % 2 == 0) || d_gnt !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d] c=%b d=%b exp c=%b", i, c_gnt, d_gnt, i % 2 == 0);
      end
      if (i % 2 == 0) expect_acc(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
      else expect_acc(1'b1, 1'b0, 3'd2, 32'h20 + 32'(4*i), 32'h0);
    end
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_lock();
    logic ec;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      set_c(i > 0, 1'b0, 3'd2, 32'h10, 32'h0);
      set_d(1'b1, 1'b0, 3'd2, 32'h200 + 32'(i), 32'h0, i < 18);
      ec = (i % 9 == 8) || (i == 18);
      #3;
      n_tests++;
      if (c_gnt !== ec || d_gnt !== !ec) begin
        n_fail++;
        $display("FAIL lock_gnt[%0d] c=%b d=%b exp c=%b", i, c_gnt, d_gnt, ec);
      end
      if (ec) expect_acc(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
      else expect_acc(1'b1, 1'b0, 3'd2, 32'h200 + 32'(i), 32'h0);
    end
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        leg;
  } op_t;

  task automatic test_bounds();
    op_t ops [9];
    ops = '{
      '{1'b1, 3'b001, 32'h0000_07FF, 32'h0000_AAAA, 1'b0},
      '{1'b0, 3'b010, 32'h0000_07FC, 32'h0,         1'b1},
      '{1'b1, 3'b010, 32'h0000_07FC, 32'hAABB_CCDD, 1'b1},
      '{1'b0, 3'b010, 32'h0000_07FC, 32'h0,         1'b1},
      '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,         1'b0},
      '{1'b0, 3'b100, 32'h0000_07FF, 32'h0,         1'b1},
      '{1'b1, 3'b100, 32'h0000_0100, 32'h5555_5555, 1'b0},
      '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         1'b0},
      '{1'b0, 3'b010, 32'h0000_07FD, 32'h0,         1'b0}
    };
    foreach (ops[i]) begin
      @(posedge clk); #1;
      set_c(1'b1, ops[i].wr, ops[i].f3, ops[i].a, ops[i].wd);
      #3;
      n_tests++;
      if (c_gnt !== 1'b1 || m_wren !== (ops[i].wr & ops[i].leg)) begin
        n_fail++;
        $display("FAIL bounds[%0d] gnt=%b wren=%b exp 1 %b", i, c_gnt, m_wren, ops[i].wr & ops[i].leg);
      end
      expect_acc(1'b0, ops[i].wr, ops[i].f3, ops[i].a, ops[i].wd);
      if (i == 0 || i == 4) begin
        @(posedge clk); #1;
        set_c(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #3;
        n_tests++;
        if (c_err !== 1'b1 || (i == 4 && c_rdata !== 32'h0)) begin
          n_fail++;
          $display("FAIL bounds_err[%0d] err=%b rd=%h exp 1", i, c_err, c_rdata);
        end
      end
    end
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    set_d(1'b1, 1'b1, 3'd2, 32'h101, 32'h1122_3344, 1'b0);
    #3;
    n_tests++;
    if (d_gnt !== 1'b1 || c_gnt !== 1'b0 || m_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_store d=%b c=%b wren=%b exp 1 0 1", d_gnt, c_gnt, m_wren);
    end
    expect_acc(1'b1, 1'b1, 3'd2, 32'h101, 32'h1122_3344);
    @(posedge clk); #1;
    set_d(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    set_c(1'b1, 1'b0, 3'd2, 32'h101, 32'h0);
    #3;
    expect_acc(1'b0, 1'b0, 3'd2, 32'h101, 32'h0);
    @(posedge clk); #1;
    set_c(1'b1, 1'b0, 3'd0, 32'h104, 32'h0);
    #3;
    n_tests++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'h1122_3344) begin
      n_fail++;
      $display("FAIL mis_word rv=%b rd=%h exp 1 11223344", c_rvalid, c_rdata);
    end
    expect_acc(1'b0, 1'b0, 3'd0, 32'h104, 32'h0);
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #3;
    n_tests++;
    if (c_rvalid !== 1'b1 || c_rdata[7:0] !== 8'h11) begin
      n_fail++;
      $display("FAIL mis_byte rv=%b rd=%h exp byte 11", c_rvalid, c_rdata[7:0]);
    end
  endtask

  task automatic test_reset_midlock();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      set_d(1'b1, 1'b0, 3'd2, 32'h300 + 32'(4*i), 32'h0, 1'b1);
      #3;
      expect_acc(1'b1, 1'b0, 3'd2, 32'h300 + 32'(4*i), 32'h0);
    end
    @(posedge clk); #1;
    set_c(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    #1 rst_n = 1'b0;
    q_c.delete(); q_d.delete();
    last_c = '0; last_d = '0;
    #1;
    n_tests++;
    if ({c_gnt, d_gnt, m_wren, c_rvalid, c_err, d_rvalid, d_err} !== 7'd0 ||
        c_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midlock_rst gnt=%b%b rv=%b%b err=%b%b rd=%h %h exp 0",
               c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, c_rdata, d_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #3;
    n_tests++;
    if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_first c=%b d=%b exp 1 0", c_gnt, d_gnt);
    end
    expect_acc(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
    @(posedge clk); #4;
    n_tests++;
    if (c_gnt !== 1'b0 || d_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_second c=%b d=%b exp 0 1", c_gnt, d_gnt);
    end
    expect_acc(1'b1, 1'b0, 3'd2, 32'h310, 32'h0);
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic        wr [2];
    logic [2:0]  f3 [2];
    logic [31:0] a [2];
    logic [31:0] wd [2];
    logic        exp_w;
    int          g;
    for (int i = 0; i < 16; i++) begin
      for (int p = 0; p < 2; p++) begin
        wr[p] = 1'($urandom_range(0, 1));
        f3[p] = 3'($urandom_range(0, 2));
        a[p]  = 32'($urandom_range(0, 2047));
        wd[p] = $urandom;
      end
      @(posedge clk); #1;
      set_c(1'b1, wr[0], f3[0], a[0], wd[0]);
      set_d(1'b1, wr[1], f3[1], a[1], wd[1], 1'b0);
      g = i % 2;
      exp_w = wr[g] & legal_acc(wr[g], f3[g], a[g]);
      #3;
      n_tests++;
      if (c_gnt !== (g == 0) || d_gnt !== (g == 1) || m_wren !== exp_w) begin
        n_fail++;
        $display("FAIL b2b[%0d] c=%b d=%b wren=%b exp c=%b wren=%b", i, c_gnt, d_gnt, m_wren, g == 0, exp_w);
      end
      expect_acc(g == 1, wr[g], f3[g], a[g], wd[g]);
    end
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    set_c(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    last_c = '0;
    last_d = '0;
    for (int k = 0; k < 2048; k++) begin
      mem[k]     = 8'h00;
      ref_mem[k] = 8'h00;
    end
    fork
      forever begin
        @(posedge clk);
        if (m_wren) begin
          for (int k = 0; k < 4; k++)
            if (k < ((m_f3[1:0] == 2'b00) ? 1 : (m_f3[1:0] == 2'b01) ? 2 : 4))
              mem[11'(m_addr + 32'(k))] <= m_wdata[8*k +: 8];
        end
      end
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (q_c.size() > 0 && q_c[0].due == cyc) begin
            mc = q_c.pop_front();
            n_tests++;
            if (c_rvalid !== mc.rv || c_err !== mc.err || c_rdata !== mc.rd) begin
              n_fail++;
              $display("FAIL c_resp cyc=%0d rv=%b err=%b rd=%h exp rv=%b err=%b rd=%h",
                       cyc, c_rvalid, c_err, c_rdata, mc.rv, mc.err, mc.rd);
            end
          end else if (c_rvalid !== 1'b0 || c_err !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL c_spurious cyc=%0d rv=%b err=%b exp 0 0", cyc, c_rvalid, c_err);
          end
          if (q_d.size() > 0 && q_d[0].due == cyc) begin
            md = q_d.pop_front();
            n_tests++;
            if (d_rvalid !== md.rv || d_err !== md.err || d_rdata !== md.rd) begin
              n_fail++;
              $display("FAIL d_resp cyc=%0d rv=%b err=%b rd=%h exp rv=%b err=%b rd=%h",
                       cyc, d_rvalid, d_err, d_rdata, md.rv, md.err, md.rd);
            end
          end else if (d_rvalid !== 1'b0 || d_err !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL d_spurious cyc=%0d rv=%b err=%b exp 0 0", cyc, d_rvalid, d_err);
          end
        end
      end
    join_none
    test_reset();
    test_core_only();
    test_round_robin();
    test_lock();
    test_bounds();
    test_misaligned();
    test_reset_midlock();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #4;
    n_tests++;
    if (q_c.size() != 0 || q_d.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending c=%0d d=%0d exp 0 0", q_c.size(), q_d.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
